// File: rtl/fp_add_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fp_add_pkg                                                             |
// | Shared types and defaults for the floating-point adder datapath.       |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
package fp_add_pkg;

  localparam int EXP_W          = 8;
  localparam int MANT_SHIFT_MAX = 27;

  // Stage-1 compare result held between the compare and shift-limit stages
  typedef struct packed {
    logic             lt;
    logic             eq;
    logic             gt;
    logic [EXP_W-1:0] abs_diff;
    logic [EXP_W-1:0] exp_big;
  } cmp_res_t;

endpackage
`default_nettype wire

// File: rtl/cmp_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cmp_core                                                               |
// | Combinational signed/unsigned magnitude comparator with |A-B|.         |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module cmp_core
  import fp_add_pkg::*;
#(
  parameter int WIDTH = EXP_W
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             lt,
  output logic             eq,
  output logic             gt,
  output logic [WIDTH-1:0] abs_diff,
  output logic [WIDTH-1:0] exp_big
);

  logic [WIDTH:0] w_ext_a;
  logic [WIDTH:0] w_ext_b;
  logic [WIDTH:0] w_diff;

  assign w_ext_a = {signed_mode & a[WIDTH-1], a};
  assign w_ext_b = {signed_mode & b[WIDTH-1], b};
  assign w_diff  = w_ext_a - w_ext_b;

  assign lt = w_diff[WIDTH];
  assign eq = (w_diff == '0);
  assign gt = !w_diff[WIDTH] && (w_diff != '0);

  // |A-B| < 2^WIDTH, so a modulo-2^WIDTH subtraction in the right order is exact
  assign abs_diff = w_diff[WIDTH] ? (b - a) : (a - b);
  assign exp_big  = w_diff[WIDTH] ? b : a;

endmodule
`default_nettype wire

// File: rtl/exp_cmp_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | exp_cmp_pipe                                                           |
// | Two-stage valid/ready exponent comparator for the FP-add align stage.  |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module exp_cmp_pipe
  import fp_add_pkg::*;
#(
  parameter  int WIDTH     = EXP_W,
  parameter  int MAX_SHIFT = MANT_SHIFT_MAX,
  localparam int SHAMT_W   = $clog2(MAX_SHIFT + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               a_lt_b,
  output logic               a_eq_b,
  output logic               a_gt_b,
  output logic [WIDTH-1:0]   abs_diff,
  output logic [SHAMT_W-1:0] shamt,
  output logic               shamt_sat,
  output logic               swap,
  output logic [WIDTH-1:0]   exp_big
);

  localparam logic [31:0] c_max_shift = MAX_SHIFT;

  logic               w_s1_adv;
  logic               w_s2_adv;
  cmp_res_t           w_s1_d;
  logic               w_sat;
  logic [SHAMT_W-1:0] w_shamt;

  logic               r_s1_v;
  cmp_res_t           r_s1;
  logic               r_s2_v;
  logic               r_lt;
  logic               r_eq;
  logic               r_gt;
  logic [WIDTH-1:0]   r_abs_diff;
  logic [SHAMT_W-1:0] r_shamt;
  logic               r_sat;
  logic [WIDTH-1:0]   r_exp_big;

  cmp_core #(.WIDTH(WIDTH)) u_cmp_core (
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .lt          (w_s1_d.lt),
    .eq          (w_s1_d.eq),
    .gt          (w_s1_d.gt),
    .abs_diff    (w_s1_d.abs_diff),
    .exp_big     (w_s1_d.exp_big)
  );

  assign w_s2_adv = !r_s2_v || out_ready;
  assign w_s1_adv = !r_s1_v || w_s2_adv;
  assign in_ready = w_s1_adv;

  assign w_sat   = 32'(r_s1.abs_diff) > c_max_shift;
  assign w_shamt = w_sat ? SHAMT_W'(MAX_SHIFT) : SHAMT_W'(r_s1.abs_diff);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_v     <= 1'b0;
      r_s1       <= '0;
      r_s2_v     <= 1'b0;
      r_lt       <= 1'b0;
      r_eq       <= 1'b0;
      r_gt       <= 1'b0;
      r_abs_diff <= '0;
      r_shamt    <= '0;
      r_sat      <= 1'b0;
      r_exp_big  <= '0;
    end else begin
      if (w_s1_adv) r_s1_v <= in_valid;
      if (w_s1_adv && in_valid) r_s1 <= w_s1_d;
      if (w_s2_adv) r_s2_v <= r_s1_v;
      // Output data only changes when a real result moves in, so it never goes stale
      if (w_s2_adv && r_s1_v) begin
        r_lt       <= r_s1.lt;
        r_eq       <= r_s1.eq;
        r_gt       <= r_s1.gt;
        r_abs_diff <= r_s1.abs_diff;
        r_shamt    <= w_shamt;
        r_sat      <= w_sat;
        r_exp_big  <= r_s1.exp_big;
      end
    end
  end

  assign out_valid = r_s2_v;
  assign a_lt_b    = r_lt;
  assign a_eq_b    = r_eq;
  assign a_gt_b    = r_gt;
  assign abs_diff  = r_abs_diff;
  assign shamt     = r_shamt;
  assign shamt_sat = r_sat;
  assign swap      = r_lt;
  assign exp_big   = r_exp_big;

endmodule
`default_nettype wire

// File: tb/tb_exp_cmp_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_exp_cmp_pipe                                                        |
// | Self-checking bench: directed vectors plus randomized scoreboard.      |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module tb_exp_cmp_pipe;

  localparam int W  = 8;
  localparam int MS = 27;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         signed_mode;
  logic         out_valid;
  logic         out_ready;
  logic         a_lt_b;
  logic         a_eq_b;
  logic         a_gt_b;
  logic [W-1:0] abs_diff;
  logic [4:0]   shamt;
  logic         shamt_sat;
  logic         swap;
  logic [W-1:0] exp_big;

  exp_cmp_pipe #(.WIDTH(W), .MAX_SHIFT(MS)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .a_lt_b      (a_lt_b),
    .a_eq_b      (a_eq_b),
    .a_gt_b      (a_gt_b),
    .abs_diff    (abs_diff),
    .shamt       (shamt),
    .shamt_sat   (shamt_sat),
    .swap        (swap),
    .exp_big     (exp_big)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   flags;  // {lt, eq, gt}
    logic [W-1:0] ad;
    logic [4:0]   sh;
    logic         sat;
    logic         sw;
    logic [W-1:0] big;
    int           t;      // edge number at which the pair was accepted
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   last_acc;

  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic sm);
    exp_t r;
    int ia, ib, d, ad;
    ia = (sm && ma[W-1]) ? int'(ma) - (1 << W) : int'(ma);
    ib = (sm && mb[W-1]) ? int'(mb) - (1 << W) : int'(mb);
    d  = ia - ib;
    ad = (d < 0) ? -d : d;
    r.flags = {d < 0, d == 0, d > 0};
    r.ad    = W'(ad);
    r.sh    = 5'((ad > MS) ? MS : ad);
    r.sat   = ad > MS;
    r.sw    = d < 0;
    r.big   = (d < 0) ? mb : ma;
    r.t     = 0;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // One clock: check at the falling edge, then apply the rising edge to the model.
  // The accepting edge loads S1 and the following edge loads the outputs.
  task automatic cycle();
    bit acc, pop;
    exp_t e;
    @(negedge clk);
    if (!rst) begin
      check("in_ready", in_ready, !(q.size() == 2 && !out_ready));
      check("out_valid", out_valid, q.size() > 0 && (cyc - q[0].t) >= 1);
      if (out_valid && q.size() > 0) begin
        check("flags", {a_lt_b, a_eq_b, a_gt_b}, q[0].flags);
        check("abs_diff", abs_diff, q[0].ad);
        check("shamt", shamt, q[0].sh);
        check("shamt_sat", shamt_sat, q[0].sat);
        check("swap", swap, q[0].sw);
        check("exp_big", exp_big, q[0].big);
      end
    end
    acc = in_valid && in_ready;
    pop = out_valid && out_ready;
    e   = model(a, b, signed_mode);
    @(posedge clk);
    cyc++;
    if (rst) begin
      q.delete();
      last_acc = 1'b0;
    end else begin
      if (pop && q.size() > 0) void'(q.pop_front());
      if (acc) begin
        e.t = cyc;
        q.push_back(e);
      end
      last_acc = acc;
    end
    #1;
  endtask

  task automatic directed(input string tag, input logic [W-1:0] da, input logic [W-1:0] db, input logic sm,
                          input logic [2:0] fl, input logic [W-1:0] ad, input logic [4:0] sh,
                          input logic sat, input logic sw, input logic [W-1:0] big);
    in_valid = 1'b1; a = da; b = db; signed_mode = sm; out_ready = 1'b0;
    cycle();
    in_valid = 1'b0;
    cycle();
    cycle();
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_flags"}, {a_lt_b, a_eq_b, a_gt_b}, fl);
    check({tag, "_abs"}, abs_diff, ad);
    check({tag, "_shamt"}, shamt, sh);
    check({tag, "_sat"}, shamt_sat, sat);
    check({tag, "_swap"}, swap, sw);
    check({tag, "_big"}, exp_big, big);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ov"}, out_valid, 0);
    check({tag, "_ir"}, in_ready, 1);
    check({tag, "_data"}, {a_lt_b, a_eq_b, a_gt_b, abs_diff, shamt, shamt_sat, swap, exp_big}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] bp_pat;
    int k;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; signed_mode = 1'b0; out_ready = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
    check_reset_state("por");

    directed("u34_27", 8'd34, 8'd27, 1'b0, 3'b001, 8'd7, 5'd7, 1'b0, 1'b0, 8'd34);
    directed("eq30", 8'd30, 8'd30, 1'b0, 3'b010, 8'd0, 5'd0, 1'b0, 1'b0, 8'd30);
    directed("u0_128", 8'd0, 8'd128, 1'b0, 3'b100, 8'd128, 5'd27, 1'b1, 1'b1, 8'd128);
    directed("s0_128", 8'd0, 8'd128, 1'b1, 3'b001, 8'd128, 5'd27, 1'b1, 1'b0, 8'd0);
    directed("s127_m128", 8'd127, 8'd128, 1'b1, 3'b001, 8'd255, 5'd27, 1'b1, 1'b0, 8'd127);
    directed("u28_0", 8'd28, 8'd0, 1'b0, 3'b001, 8'd28, 5'd27, 1'b1, 1'b0, 8'd28);
    directed("u0_27", 8'd0, 8'd27, 1'b0, 3'b100, 8'd27, 5'd27, 1'b0, 1'b1, 8'd27);

    // Six back-to-back pairs against a 1,0,0,1 out_ready pattern
    bp_pat = 4'b1001;
    k = 0;
    a = W'($urandom); b = W'($urandom); signed_mode = 1'($urandom);
    for (int c = 0; c < 40; c++) begin
      in_valid  = (k < 6);
      out_ready = bp_pat[c % 4];
      cycle();
      if (last_acc) begin
        k++;
        a = W'($urandom); b = W'($urandom); signed_mode = 1'($urandom);
      end
    end
    in_valid = 1'b0;
    check("bp_count", k, 6);
    check("bp_drained", q.size(), 0);

    // Reset with both stages occupied
    out_ready = 1'b0;
    in_valid = 1'b1; a = 8'd5; b = 8'd9; signed_mode = 1'b0;
    cycle();
    a = 8'd200; b = 8'd3;
    cycle();
    in_valid = 1'b0;
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check_reset_state("midrst");
    directed("post_rst", 8'd10, 8'd40, 1'b0, 3'b100, 8'd30, 5'd27, 1'b1, 1'b1, 8'd40);

    // Randomized traffic with random backpressure
    in_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!in_valid || last_acc) begin
        in_valid    = ($urandom_range(0, 3) != 0);
        a           = W'($urandom);
        b           = ($urandom_range(0, 7) == 0) ? a : W'($urandom);
        signed_mode = 1'($urandom);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end

    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10 && q.size() > 0; c++) cycle();
    check("final_drain", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
